// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  // Select codes follow the mux Ctrl encoding.
  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/resource-facing bundle of the 4-way round-robin mux arbiter.
interface mux4_rr_arbiter_if;
  // Handshake: a requester holds req[i] high until it sees gnt[i]; the resource
  // gets a one-cycle res_start with each grant and answers with a one-cycle res_done.
  logic [mux4_arb_pkg::NREQ-1:0]  req;
  logic                           res_done;
  logic [mux4_arb_pkg::SEL_W-1:0] sel;
  logic [mux4_arb_pkg::NREQ-1:0]  gnt;
  logic                           res_start;
  logic                           busy;
  logic                           timeout;

  modport master (
    input  req, res_done,
    output sel, gnt, res_start, busy, timeout
  );

  modport slave (
    output req, res_done,
    input  sel, gnt, res_start, busy, timeout
  );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational circular priority picker: first set request scanning up from ptr.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr_i + SEL_W'(i);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4-input mux: grant, start strobe, hold until done or timeout.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.master bus,
  output logic             dbg_state_o,
  output logic [SEL_W-1:0] dbg_ptr_o
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             to_q, to_d;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= SEL_A;
      ptr_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      to_q    <= to_d;
    end
  end

  // sel_q doubles as the current winner while BUSY, and is left alone in IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_BUSY;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (bus.res_done) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 1'b1;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.res_start = start_q;
  assign bus.timeout   = to_q;
  assign bus.busy      = (state_q == S_BUSY);
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single grant, rotation, timeout, coincident done, async reset, stray done.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [1:0] dbg_ptr;
  int         n_cmp;
  int         n_err;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.TIMEOUT(16), .TO_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic st, input logic b, input logic t);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".start"}, 32'(bus.res_start), 32'(st));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.req      = 4'b0000;
    bus.res_done = 1'b0;
    #1;
    chk_out("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("reset.ptr", 32'(dbg_ptr), 32'd0);
    chk("reset.state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);

    // Single requester C, released by done.
    bus.req = 4'b0100;
    step();
    chk_out("grantC", 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    chk_out("holdC", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    step();
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk_out("doneC", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("doneC.ptr", 32'(dbg_ptr), 32'd3);

    // All four requesting: 0,1,2,3,0 from ptr=0 with one idle cycle between grants.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_g = 4'b0001 << (k % 4);
      chk_out($sformatf("rot%0d", k), exp_g, 2'(k % 4), 1'b1, 1'b1, 1'b0);
      step();
      step();
      bus.res_done = 1'b1;
      step();
      bus.res_done = 1'b0;
      chk_out($sformatf("rot%0d_idle", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0, 1'b0);
      if (k == 4) bus.req = 4'b0000;
    end
    step();
    chk_out("rot_end", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rot_end.ptr", 32'(dbg_ptr), 32'd1);

    // Timeout: requester B held 16 cycles with no done.
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      chk_out($sformatf("to_hold%0d", k), 4'b0010, 2'b01, (k == 0), 1'b1, 1'b0);
      step();
    end
    chk_out("to_fire", 4'b0000, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("to_fire.ptr", 32'(dbg_ptr), 32'd2);
    step();
    chk_out("to_after", 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0);

    // ptr=2 scans 2,3,0: winner is A.
    bus.req = 4'b0011;
    step();
    bus.req = 4'b0000;
    chk_out("wrapA", 4'b0001, 2'b00, 1'b1, 1'b1, 1'b0);

    // Done on the timeout-expiry cycle: release without timeout pulse.
    for (int k = 0; k < 15; k++) step();
    chk("coin.gnt_pre", 32'(bus.gnt), 32'h1);
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk_out("coin", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("coin.ptr", 32'(dbg_ptr), 32'd1);
    step();
    chk("coin_after.timeout", 32'(bus.timeout), 32'd0);

    // Async reset between clock edges while granting D.
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    chk_out("grantD", 4'b1000, 2'b11, 1'b1, 1'b1, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("async_rst.ptr", 32'(dbg_ptr), 32'd0);
    step();
    rst_n   = 1'b1;
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    chk_out("regrantD", 4'b1000, 2'b11, 1'b1, 1'b1, 1'b0);
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk("regrantD.ptr_wrap", 32'(dbg_ptr), 32'd0);

    // Requester drops req mid-BUSY; grant persists. Then a stray done in IDLE.
    bus.req = 4'b0100;
    step();
    chk_out("dropC", 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
    bus.req = 4'b0000;
    step();
    step();
    step();
    chk_out("dropC_hold", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk_out("dropC_rel", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    step();
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk_out("stray_done", 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("stray_done.ptr", 32'(dbg_ptr), 32'd3);
    chk("stray_done.state", 32'(dbg_state), 32'd0);

    // Single requester again: ptr=3 wraps back around to C.
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    chk_out("again_C", 4'b0100, 2'b10, 1'b1, 1'b1, 1'b0);
    bus.res_done = 1'b1;
    step();
    bus.res_done = 1'b0;
    chk("again_C.ptr", 32'(dbg_ptr), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
